// File: rtl/board_mem_ctrl_pkg.sv
// Shared types for the game-board memory slice.
//   cell_t    : stored cell codes (EMPTY / P1 / P2)
//   op_t      : command opcodes
//   err_t     : response codes
//   state_t   : controller FSM states
//   swap_code : bit-swapped packing of a cell code onto game_board
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P2    = 2'b10,
        P1    = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_UNDO  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NOP   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ERR_OK         = 2'b00,
        ERR_ILLEGAL    = 2'b01,
        ERR_OCCUPIED   = 2'b10,
        ERR_HIST_EMPTY = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CLR  = 2'b01,
        S_RSP  = 2'b10
    } state_t;

    // Display side expects code[1] in the low bit of each cell slot.
    function automatic logic [1:0] swap_code(input logic [1:0] c);
        return {c[0], c[1]};
    endfunction

endpackage

// File: rtl/board_mem_ctrl_if.sv
// Command / response / board-state bundle for board_mem_ctrl.
//   master : move-input side (drives cmd_*, observes everything else)
//   slave  : board_mem_ctrl itself
interface board_mem_ctrl_if
    import board_pkg::*;
#(
    parameter int N      = 3,
    parameter int ADDR_W = $clog2(N*N) + 1,
    parameter int CNT_W  = $clog2(N*N + 1)
);
    logic                cmd_valid;
    logic                cmd_ready;
    op_t                 cmd_op;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [1:0]          cmd_state;
    logic                rsp_valid;
    err_t                rsp_err;
    logic [2*N*N-1:0]    game_board;
    logic [CNT_W-1:0]    move_count;
    logic                board_full;
    logic [ADDR_W-1:0]   last_addr;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_state,
        input  cmd_ready, rsp_valid, rsp_err, game_board, move_count, board_full, last_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_state,
        output cmd_ready, rsp_valid, rsp_err, game_board, move_count, board_full, last_addr
    );
endinterface

// File: rtl/board_hist_stack.sv
// Move-history LIFO.
//   ph1, reset_n : clock / async active-low reset
//   push_i       : push din_i
//   pop_i        : drop top entry (ignored when empty)
//   clr_i        : empty the stack (wins over push/pop)
//   top_o        : current top entry ('0 when empty)
//   empty_o      : no entries held
module board_hist_stack #(
    parameter int DEPTH = 9,
    parameter int W     = 4
) (
    input  logic         ph1,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clr_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] top_o,
    output logic         empty_o
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0] sp_q, sp_d;
    logic [W-1:0]    mem_q [DEPTH];

    assign empty_o = (sp_q == '0);

    always_comb begin
        sp_d = sp_q;
        if (clr_i)
            sp_d = '0;
        else if (push_i)
            sp_d = sp_q + 1'b1;
        else if (pop_i && !empty_o)
            sp_d = sp_q - 1'b1;
    end

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n)
            sp_q <= '0;
        else
            sp_q <= sp_d;
    end

    // Storage needs no reset: only entries below sp_q are ever read.
    always_ff @(posedge ph1) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (push_i && !clr_i && SP_W'(k) == sp_q)
                mem_q[k] <= din_i;
        end
    end

    always_comb begin
        top_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (SP_W'(k + 1) == sp_q)
                top_o = mem_q[k];
        end
    end
endmodule

// File: rtl/board_mem_ctrl.sv
// NxN game-board memory with command handshake, move counter, undo history
// and a one-cell-per-cycle sequenced clear.
//   ph1     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : board_mem_ctrl_if.slave (cmd_* in; cmd_ready, rsp_*, game_board,
//             move_count, board_full, last_addr out)
module board_mem_ctrl
    import board_pkg::*;
#(
    parameter int N      = 3,
    parameter int ADDR_W = $clog2(N*N) + 1,
    parameter int CNT_W  = $clog2(N*N + 1)
) (
    input  logic             ph1,
    input  logic             reset_n,
    board_mem_ctrl_if.slave  bus
);
    localparam int CELLS = N * N;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ci_q, ci_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    err_t              err_q, err_d;

    logic              do_write, do_undo, do_clr;
    logic              addr_ok, cur_occ;
    logic [CELLS-1:0]  occ;
    logic [ADDR_W-1:0] hist_top;
    logic              hist_empty;

    assign addr_ok = (bus.cmd_addr < ADDR_W'(CELLS));

    always_comb begin
        cur_occ = 1'b0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (ADDR_W'(i) == bus.cmd_addr && occ[i])
                cur_occ = 1'b1;
        end
    end

    // Next-state and command decode; state changes only on an accepted command in IDLE.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        ci_d     = ci_q;
        cnt_d    = cnt_q;
        do_write = 1'b0;
        do_undo  = 1'b0;
        do_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_WRITE: begin
                            state_d = S_RSP;
                            if (!addr_ok || !bus.cmd_state[1])
                                err_d = ERR_ILLEGAL;
                            else if (cur_occ)
                                err_d = ERR_OCCUPIED;
                            else begin
                                err_d    = ERR_OK;
                                do_write = 1'b1;
                                cnt_d    = cnt_q + 1'b1;
                            end
                        end
                        OP_UNDO: begin
                            state_d = S_RSP;
                            if (hist_empty)
                                err_d = ERR_HIST_EMPTY;
                            else begin
                                err_d   = ERR_OK;
                                do_undo = 1'b1;
                                cnt_d   = cnt_q - 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            state_d = S_CLR;
                            err_d   = ERR_OK;
                            do_clr  = 1'b1;
                            ci_d    = '0;
                            cnt_d   = '0;
                        end
                        default: begin
                            state_d = S_RSP;
                            err_d   = ERR_OK;
                        end
                    endcase
                end
            end
            S_CLR: begin
                ci_d = ci_q + 1'b1;
                if (ci_q == ADDR_W'(CELLS - 1))
                    state_d = S_RSP;
            end
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ci_q    <= '0;
            cnt_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            ci_q    <= ci_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    board_hist_stack #(
        .DEPTH (CELLS),
        .W     (ADDR_W)
    ) u_hist (
        .ph1     (ph1),
        .reset_n (reset_n),
        .push_i  (do_write),
        .pop_i   (do_undo),
        .clr_i   (do_clr),
        .din_i   (bus.cmd_addr),
        .top_o   (hist_top),
        .empty_o (hist_empty)
    );

    for (genvar g = 0; g < CELLS; g++) begin : g_cell
        logic [1:0] cell_q;

        // Undo clears the cell named by the history top before it is popped.
        always_ff @(posedge ph1 or negedge reset_n) begin
            if (!reset_n)
                cell_q <= EMPTY;
            else if (do_write && bus.cmd_addr == ADDR_W'(g))
                cell_q <= bus.cmd_state;
            else if (do_undo && hist_top == ADDR_W'(g))
                cell_q <= EMPTY;
            else if (state_q == S_CLR && ci_q == ADDR_W'(g))
                cell_q <= EMPTY;
        end

        assign occ[g]                = (cell_q != EMPTY);
        assign bus.game_board[2*g +: 2] = swap_code(cell_q);
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.rsp_valid  = (state_q == S_RSP);
    assign bus.rsp_err    = err_q;
    assign bus.move_count = cnt_q;
    assign bus.board_full = (cnt_q == CNT_W'(CELLS));
    assign bus.last_addr  = hist_empty ? '0 : hist_top;
endmodule

// File: tb/tb_board_mem_ctrl.sv
module tb_board_mem_ctrl;
    import board_pkg::*;

    logic ph1;
    logic reset_n;

    board_mem_ctrl_if #(.N(3)) bus3 ();
    board_mem_ctrl_if #(.N(4)) bus4 ();

    board_mem_ctrl #(.N(3)) dut3 (.ph1(ph1), .reset_n(reset_n), .bus(bus3));
    board_mem_ctrl #(.N(4)) dut4 (.ph1(ph1), .reset_n(reset_n), .bus(bus4));

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    typedef struct {
        op_t         op;
        logic [4:0]  addr;
        logic [1:0]  st;
        err_t        err;
        logic [3:0]  cnt;
        logic [4:0]  last;
        logic [17:0] board;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(op_t op, int a, int st, err_t err, int cnt, int last,
                                logic [17:0] b, int lat);
        vec_t v;
        v.op = op; v.addr = 5'(a); v.st = 2'(st); v.err = err;
        v.cnt = 4'(cnt); v.last = 5'(last); v.board = b; v.lat = lat;
        return v;
    endfunction

    // Scoreboard: every rsp_valid pulse consumes the oldest expectation.
    always @(negedge ph1) begin
        if (reset_n && bus3.rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL spurious_rsp: got rsp_valid=1 expected none");
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk("rsp_err",    32'(bus3.rsp_err),    32'(e.err));
                chk("move_count", 32'(bus3.move_count), 32'(e.cnt));
                chk("last_addr",  32'(bus3.last_addr),  32'(e.last));
                chk("game_board", 32'(bus3.game_board), 32'(e.board));
                chk("board_full", 32'(bus3.board_full), 32'(e.cnt == 4'd9));
            end
        end
    end

    task automatic send(input vec_t v, output int lat, output int ready_low);
        int w;
        lat = 0;
        ready_low = 0;
        @(negedge ph1);
        bus3.cmd_valid = 1'b1;
        bus3.cmd_op    = v.op;
        bus3.cmd_addr  = v.addr;
        bus3.cmd_state = v.st;
        w = 0;
        while (!bus3.cmd_ready && w < 30) begin
            @(negedge ph1);
            w++;
        end
        exp_q.push_back(v);
        @(posedge ph1);
        #1 bus3.cmd_valid = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge ph1);
            #1;
            if (exp_q.size() == 0) begin
                lat = k;
                break;
            end
            if (!bus3.cmd_ready) ready_low++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat, rl;
        logic [31:0] gb4;

        bus3.cmd_valid = 1'b0; bus3.cmd_op = OP_NOP; bus3.cmd_addr = '0; bus3.cmd_state = '0;
        bus4.cmd_valid = 1'b0; bus4.cmd_op = OP_NOP; bus4.cmd_addr = '0; bus4.cmd_state = '0;

        vecs.push_back(mk(OP_WRITE, 4,  3, ERR_OK,         1, 4, 18'h00300, 1));
        vecs.push_back(mk(OP_WRITE, 4,  2, ERR_OCCUPIED,   1, 4, 18'h00300, 1));
        vecs.push_back(mk(OP_WRITE, 9,  3, ERR_ILLEGAL,    1, 4, 18'h00300, 1));
        vecs.push_back(mk(OP_WRITE, 0,  1, ERR_ILLEGAL,    1, 4, 18'h00300, 1));
        vecs.push_back(mk(OP_UNDO,  0,  0, ERR_OK,         0, 0, 18'h00000, 1));
        vecs.push_back(mk(OP_UNDO,  0,  0, ERR_HIST_EMPTY, 0, 0, 18'h00000, 1));
        vecs.push_back(mk(OP_WRITE, 0,  3, ERR_OK,         1, 0, 18'h00003, 1));
        vecs.push_back(mk(OP_WRITE, 1,  2, ERR_OK,         2, 1, 18'h00007, 1));
        vecs.push_back(mk(OP_WRITE, 2,  3, ERR_OK,         3, 2, 18'h00037, 1));
        vecs.push_back(mk(OP_UNDO,  0,  0, ERR_OK,         2, 1, 18'h00007, 1));
        vecs.push_back(mk(OP_UNDO,  0,  0, ERR_OK,         1, 0, 18'h00003, 1));
        vecs.push_back(mk(OP_UNDO,  0,  0, ERR_OK,         0, 0, 18'h00000, 1));
        vecs.push_back(mk(OP_UNDO,  0,  0, ERR_HIST_EMPTY, 0, 0, 18'h00000, 1));
        vecs.push_back(mk(OP_NOP,   5,  3, ERR_OK,         0, 0, 18'h00000, 1));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(OP_WRITE, i, 3, ERR_OK, i + 1, i, 18'h3FFFF >> (16 - 2*i), 1));
        vecs.push_back(mk(OP_WRITE, 5,  2, ERR_OCCUPIED,   9, 8, 18'h3FFFF, 1));
        vecs.push_back(mk(OP_WRITE, 9,  3, ERR_ILLEGAL,    9, 8, 18'h3FFFF, 1));
        vecs.push_back(mk(OP_WRITE, 31, 3, ERR_ILLEGAL,    9, 8, 18'h3FFFF, 1));
        vecs.push_back(mk(OP_CLEAR, 0,  0, ERR_OK,         0, 0, 18'h00000, 10));
        vecs.push_back(mk(OP_UNDO,  0,  0, ERR_HIST_EMPTY, 0, 0, 18'h00000, 1));
        vecs.push_back(mk(OP_WRITE, 8,  2, ERR_OK,         1, 8, 18'h10000, 1));

        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        repeat (3) @(negedge ph1);
        chk("rst_cmd_ready",  32'(bus3.cmd_ready),  32'd1);
        chk("rst_rsp_valid",  32'(bus3.rsp_valid),  32'd0);
        chk("rst_rsp_err",    32'(bus3.rsp_err),    32'd0);
        chk("rst_board",      32'(bus3.game_board), 32'd0);
        chk("rst_count",      32'(bus3.move_count), 32'd0);
        chk("rst_last",       32'(bus3.last_addr),  32'd0);
        chk("rst_full",       32'(bus3.board_full), 32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            send(vecs[i], lat, rl);
            chk($sformatf("latency[%0d]", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].op == OP_CLEAR)
                chk("clear_ready_low", 32'(rl), 32'd9);
        end

        // Asynchronous reset in the middle of a CLEAR (cell 8 still occupied).
        @(negedge ph1);
        bus3.cmd_valid = 1'b1; bus3.cmd_op = OP_CLEAR;
        @(posedge ph1);
        #1 bus3.cmd_valid = 1'b0;
        repeat (4) @(posedge ph1);
        #2;
        chk("midclr_ready",   32'(bus3.cmd_ready),  32'd0);
        chk("midclr_board",   32'(bus3.game_board), 32'h10000);
        reset_n = 1'b0;
        #1;
        chk("arst_cmd_ready", 32'(bus3.cmd_ready),  32'd1);
        chk("arst_rsp_valid", 32'(bus3.rsp_valid),  32'd0);
        chk("arst_board",     32'(bus3.game_board), 32'd0);
        chk("arst_count",     32'(bus3.move_count), 32'd0);
        chk("arst_last",      32'(bus3.last_addr),  32'd0);
        repeat (2) @(negedge ph1);
        reset_n = 1'b1;
        @(negedge ph1);
        chk("post_rst_ready", 32'(bus3.cmd_ready),  32'd1);
        send(mk(OP_UNDO, 0, 0, ERR_HIST_EMPTY, 0, 0, 18'h0, 1), lat, rl);
        chk("post_rst_undo_lat", 32'(lat), 32'd1);

        // N=4 instance: highest legal cell and first out-of-range index.
        @(negedge ph1);
        bus4.cmd_valid = 1'b1; bus4.cmd_op = OP_WRITE; bus4.cmd_addr = 5'd15; bus4.cmd_state = 2'b10;
        @(posedge ph1);
        #1 bus4.cmd_valid = 1'b0;
        @(negedge ph1);
        gb4 = bus4.game_board;
        chk("n4_rsp_valid",   32'(bus4.rsp_valid),  32'd1);
        chk("n4_rsp_err",     32'(bus4.rsp_err),    32'(ERR_OK));
        chk("n4_cell15",      32'(gb4[31:30]),      32'd1);
        chk("n4_count",       32'(bus4.move_count), 32'd1);
        chk("n4_last",        32'(bus4.last_addr),  32'd15);
        @(negedge ph1);
        bus4.cmd_valid = 1'b1; bus4.cmd_op = OP_WRITE; bus4.cmd_addr = 5'd16; bus4.cmd_state = 2'b11;
        @(posedge ph1);
        #1 bus4.cmd_valid = 1'b0;
        @(negedge ph1);
        chk("n4_ill_valid",   32'(bus4.rsp_valid),  32'd1);
        chk("n4_ill_err",     32'(bus4.rsp_err),    32'(ERR_ILLEGAL));
        chk("n4_ill_count",   32'(bus4.move_count), 32'd1);

        repeat (3) @(negedge ph1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
